// File: rtl/train_track_emulator.sv
// train_track_emulator: cycle-based plant model of a two-train layout whose loops share a
// stretch of track. It turns controller commands (sw1/sw2, da0/db0) into track sensors s1..s4
// and flags derailments and collisions.
//
// Optional feature: define TRAIN_EMU_LAP_CNT_EN to build the saturating lap counters.
// Without it, lap_a/lap_b are tied to zero and no counter logic is generated.
module train_track_emulator #(
    parameter int unsigned LOOP_LEN = 16,
    parameter int unsigned SH_START = 6,
    parameter int unsigned SH_END   = 9,
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned A_START  = 0,
    parameter int unsigned B_START  = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        run,
    input  logic                        clr,
    input  logic                        sw1,
    input  logic                        sw2,
    input  logic                        da0,
    input  logic                        db0,
    output logic                        s1,
    output logic                        s2,
    output logic                        s3,
    output logic                        s4,
    output logic [$clog2(LOOP_LEN)-1:0] pos_a,
    output logic [$clog2(LOOP_LEN)-1:0] pos_b,
    output logic                        derail_a,
    output logic                        derail_b,
    output logic                        collision,
    output logic                        fault,
    output logic [7:0]                  lap_a,
    output logic [7:0]                  lap_b
);

    localparam int unsigned PW = $clog2(LOOP_LEN);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0] POS_LAST  = PW'(LOOP_LEN - 1);
    localparam logic [PW-1:0] POS_APPR  = PW'(SH_START - 1);
    localparam logic [PW-1:0] POS_SH_S  = PW'(SH_START);
    localparam logic [PW-1:0] POS_SH_E  = PW'(SH_END);
    localparam logic [PW-1:0] POS_EXIT  = PW'(SH_END + 1);
    localparam logic [PW-1:0] POS_A_RST = PW'(A_START);
    localparam logic [PW-1:0] POS_B_RST = PW'(B_START);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFault} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [PW-1:0] pos_a_q, pos_a_d;
    logic [PW-1:0] pos_b_q, pos_b_d;
    logic          derail_a_q, derail_a_d;
    logic          derail_b_q, derail_b_d;
    logic          collision_q, collision_d;

    logic          in_run;
    logic          step;
    logic          move_a, move_b;
    logic          det_derail_a, det_derail_b, det_collision, det_fault;
    logic          clr_flags;
    logic [PW-1:0] inc_a, inc_b;

    // ------------------------------------------------------------------
    // Movement and fault detection on the step being taken
    // ------------------------------------------------------------------

    // Step strobe, candidate next positions and fault detection
    always_comb begin
        step   = in_run && (tick_q == TICK_LAST);
        move_a = step && da0;
        move_b = step && db0;

        inc_a  = (pos_a_q == POS_LAST) ? '0 : pos_a_q + 1'b1;
        inc_b  = (pos_b_q == POS_LAST) ? '0 : pos_b_q + 1'b1;

        pos_a_d = move_a ? inc_a : pos_a_q;
        pos_b_d = move_b ? inc_b : pos_b_q;

        // Train A must see both switches routed for A (0), train B for B (1)
        det_derail_a = move_a && (((pos_a_q == POS_APPR) && sw1)
                                  || ((pos_a_q == POS_SH_E) && sw2));
        det_derail_b = move_b && (((pos_b_q == POS_APPR) && !sw1)
                                  || ((pos_b_q == POS_SH_E) && !sw2));

        det_collision = step
                        && (pos_a_d >= POS_SH_S) && (pos_a_d <= POS_SH_E)
                        && (pos_b_d >= POS_SH_S) && (pos_b_d <= POS_SH_E);

        det_fault = det_derail_a || det_derail_b || det_collision;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a fault outranks run being dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (det_fault) begin
                    state_d = StFault;
                end else if (!run) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                if (clr) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM-derived outputs and qualifiers
    always_comb begin
        in_run    = (state_q == StRun);
        fault     = (state_q == StFault);
        clr_flags = (state_q == StFault) && clr;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------

    // Prescaler: counts only while staying in RUN, zero otherwise
    always_comb begin
        tick_d = '0;
        if (in_run && (state_d == StRun)) begin
            tick_d = step ? '0 : tick_q + 1'b1;
        end
    end

    // Sticky fault flags: set on detection, cleared only by clr in FAULT
    always_comb begin
        derail_a_d  = derail_a_q;
        derail_b_d  = derail_b_q;
        collision_d = collision_q;
        if (clr_flags) begin
            derail_a_d  = 1'b0;
            derail_b_d  = 1'b0;
            collision_d = 1'b0;
        end
        if (det_derail_a) begin
            derail_a_d = 1'b1;
        end
        if (det_derail_b) begin
            derail_b_d = 1'b1;
        end
        if (det_collision) begin
            collision_d = 1'b1;
        end
    end

    // Prescaler, positions and flags; positions still move on a faulting step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q      <= '0;
            pos_a_q     <= POS_A_RST;
            pos_b_q     <= POS_B_RST;
            derail_a_q  <= 1'b0;
            derail_b_q  <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            pos_a_q     <= pos_a_d;
            pos_b_q     <= pos_b_d;
            derail_a_q  <= derail_a_d;
            derail_b_q  <= derail_b_d;
            collision_q <= collision_d;
        end
    end

    // ------------------------------------------------------------------
    // Lap counters
    // ------------------------------------------------------------------

`ifdef TRAIN_EMU_LAP_CNT_EN
    logic [7:0] lap_a_q, lap_b_q;

    // Count LOOP_LEN-1 -> 0 wraps, saturating at 255; only rst clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_a_q <= '0;
            lap_b_q <= '0;
        end else begin
            if (move_a && (pos_a_q == POS_LAST) && (lap_a_q != 8'hFF)) begin
                lap_a_q <= lap_a_q + 8'd1;
            end
            if (move_b && (pos_b_q == POS_LAST) && (lap_b_q != 8'hFF)) begin
                lap_b_q <= lap_b_q + 8'd1;
            end
        end
    end

    assign lap_a = lap_a_q;
    assign lap_b = lap_b_q;
`else
    assign lap_a = '0;
    assign lap_b = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Sensors decode the position registers directly
    always_comb begin
        s1 = (pos_a_q == POS_APPR);
        s2 = (pos_b_q == POS_APPR);
        s3 = (pos_b_q == POS_EXIT);
        s4 = (pos_a_q == POS_EXIT);
    end

    assign pos_a     = pos_a_q;
    assign pos_b     = pos_b_q;
    assign derail_a  = derail_a_q;
    assign derail_b  = derail_b_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_train_track_emulator.sv
// Testbench for train_track_emulator: directed vector table for free running, hand-written
// sequences for hold, reset, derail and collision, and a closed-loop run against a small
// track controller built into the bench.
module tb_train_track_emulator;

`ifdef TRAIN_EMU_LAP_CNT_EN
    localparam int LAPEN = 1;
`else
    localparam int LAPEN = 0;
`endif

    localparam int OWN_NONE = 0;
    localparam int OWN_A    = 1;
    localparam int OWN_B    = 2;

    logic       clk = 1'b0;
    logic       rst, run, clr;
    logic       sw1, sw2, da0, db0;
    logic       s1, s2, s3, s4;
    logic [3:0] pos_a, pos_b;
    logic       derail_a, derail_b, collision, fault;
    logic [7:0] lap_a, lap_b;

    // Directed drive and closed-loop controller drive, muxed onto the DUT
    logic d_sw1, d_sw2, d_da0, d_db0;
    logic cl_en;
    logic cl_sw1, cl_sw2;
    int   owner;

    assign sw1 = cl_en ? cl_sw1 : d_sw1;
    assign sw2 = cl_en ? cl_sw2 : d_sw2;
    assign da0 = cl_en ? !(s1 && owner != OWN_A) : d_da0;
    assign db0 = cl_en ? !(s2 && owner != OWN_B) : d_db0;

    int nchk = 0;
    int nerr = 0;

    train_track_emulator dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .clr       (clr),
        .sw1       (sw1),
        .sw2       (sw2),
        .da0       (da0),
        .db0       (db0),
        .s1        (s1),
        .s2        (s2),
        .s3        (s3),
        .s4        (s4),
        .pos_a     (pos_a),
        .pos_b     (pos_b),
        .derail_a  (derail_a),
        .derail_b  (derail_b),
        .collision (collision),
        .fault     (fault),
        .lap_a     (lap_a),
        .lap_b     (lap_b)
    );

    always #5 clk = ~clk;

    // Track controller: grants the shared section to one train at a time
    always @(negedge clk) begin
        if (cl_en) begin
            if (owner == OWN_NONE) begin
                if (s1) begin
                    owner  = OWN_A;
                    cl_sw1 = 1'b0;
                    cl_sw2 = 1'b0;
                end else if (s2) begin
                    owner  = OWN_B;
                    cl_sw1 = 1'b1;
                    cl_sw2 = 1'b1;
                end
            end else if (owner == OWN_A && s4) begin
                owner = OWN_NONE;
            end else if (owner == OWN_B && s3) begin
                owner = OWN_NONE;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        nchk++;
        if (act != exp_v) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         cyc;
        int         pa;
        int         pb;
        logic [3:0] sens;  // {s4, s3, s2, s1}
        int         lap;
        string      nm;
    } vec_t;

    vec_t fr[11];

    initial begin
        int  laps_a, laps_b, fault_cycles;
        int  pa_prev, pb_prev;
        bit  held_ok;

        // Free-run vectors: cycles since previous entry, then expected state
        fr[0]  = '{1,  0,  12, 4'b0000, 0, "run_entry"};
        fr[1]  = '{4,  1,  12, 4'b0000, 0, "first_step"};
        fr[2]  = '{15, 4,  12, 4'b0000, 0, "pos4"};
        fr[3]  = '{1,  5,  12, 4'b0001, 0, "s1_rise"};
        fr[4]  = '{3,  5,  12, 4'b0001, 0, "s1_hold4"};
        fr[5]  = '{1,  6,  12, 4'b0000, 0, "s1_fall"};
        fr[6]  = '{16, 10, 12, 4'b1000, 0, "s4_rise"};
        fr[7]  = '{3,  10, 12, 4'b1000, 0, "s4_hold4"};
        fr[8]  = '{1,  11, 12, 4'b0000, 0, "s4_fall"};
        fr[9]  = '{16, 15, 12, 4'b0000, 0, "pos15"};
        fr[10] = '{4,  0,  12, 4'b0000, 1, "wrap"};

        rst = 1'b1; run = 1'b0; clr = 1'b0; cl_en = 1'b0; owner = OWN_NONE;
        cl_sw1 = 1'b0; cl_sw2 = 1'b0;
        d_sw1 = 1'b0; d_sw2 = 1'b0; d_da0 = 1'b0; d_db0 = 1'b0;
        #2;
        chk("rst_pos_a", pos_a, 0);
        chk("rst_pos_b", pos_b, 12);
        chk("rst_sensors", {s4, s3, s2, s1}, 0);
        chk("rst_flags", {derail_a, derail_b, collision, fault}, 0);
        chk("rst_laps", {lap_a, lap_b}, 0);

        // Free run: train A only
        tick();
        rst = 1'b0; run = 1'b1; d_da0 = 1'b1;
        for (int i = 0; i < 11; i++) begin
            repeat (fr[i].cyc) tick();
            chk({fr[i].nm, "_pos_a"}, pos_a, fr[i].pa);
            chk({fr[i].nm, "_pos_b"}, pos_b, fr[i].pb);
            chk({fr[i].nm, "_sensors"}, {s4, s3, s2, s1}, fr[i].sens);
            chk({fr[i].nm, "_lap_a"}, lap_a, fr[i].lap * LAPEN);
            chk({fr[i].nm, "_fault"}, fault, 0);
        end

        // Hold at the approach position
        repeat (20) tick();
        chk("hold_arrive", pos_a, 5);
        d_da0 = 1'b0;
        held_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pos_a != 4'd5 || s1 != 1'b1) held_ok = 1'b0;
        end
        chk("hold_100", held_ok, 1);
        d_da0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (pos_a == 4'd6) break;
        end
        chk("hold_release", pos_a, 6);

        // Asynchronous reset mid-run, checked before any clock edge
        rst = 1'b1;
        #1;
        chk("arst_pos_a", pos_a, 0);
        chk("arst_pos_b", pos_b, 12);
        chk("arst_sensors", {s4, s3, s2, s1}, 0);
        chk("arst_flags", {derail_a, derail_b, collision, fault}, 0);

        // Derail: A enters the shared section with sw1 routed for B
        tick();
        rst = 1'b0; d_sw1 = 1'b1; d_da0 = 1'b1; run = 1'b1;
        repeat (24) tick();
        chk("derail_pre_pos", pos_a, 5);
        chk("derail_pre_fault", fault, 0);
        tick();
        chk("derail_pos", pos_a, 6);
        chk("derail_a", derail_a, 1);
        chk("derail_fault", fault, 1);
        chk("derail_other", {derail_b, collision}, 0);
        repeat (8) tick();
        chk("derail_frozen_a", pos_a, 6);
        chk("derail_frozen_b", pos_b, 12);
        chk("derail_sticky", {derail_a, fault}, 3);
        clr = 1'b1;
        tick();
        clr = 1'b0; d_sw1 = 1'b0;
        chk("clr_fault", fault, 0);
        chk("clr_flags", {derail_a, derail_b, collision}, 0);
        repeat (4) tick();
        chk("resume_wait", pos_a, 6);
        tick();
        chk("resume_step", pos_a, 7);

        // Collision: A parked at 7, B enters the shared section correctly routed
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0; run = 1'b1; d_da0 = 1'b1; d_db0 = 1'b0; d_sw1 = 1'b0; d_sw2 = 1'b0;
        repeat (29) tick();
        chk("coll_park", pos_a, 7);
        d_da0 = 1'b0; d_db0 = 1'b1; d_sw1 = 1'b1; d_sw2 = 1'b1;
        repeat (36) tick();
        chk("coll_b_appr", pos_b, 5);
        chk("coll_s2", s2, 1);
        repeat (3) tick();
        chk("coll_pre_fault", fault, 0);
        tick();
        chk("coll_pos_b", pos_b, 6);
        chk("coll_pos_a", pos_a, 7);
        chk("collision", collision, 1);
        chk("coll_no_derail", {derail_a, derail_b}, 0);
        chk("coll_fault", fault, 1);

        // Closed loop against the bench controller
        rst = 1'b1; run = 1'b0; cl_en = 1'b1; owner = OWN_NONE;
        #1;
        tick();
        rst = 1'b0; run = 1'b1;
        laps_a = 0; laps_b = 0; fault_cycles = 0;
        pa_prev = pos_a; pb_prev = pos_b;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (fault) fault_cycles++;
            if (pa_prev == 15 && pos_a == 4'd0) laps_a++;
            if (pb_prev == 15 && pos_b == 4'd0) laps_b++;
            pa_prev = pos_a;
            pb_prev = pos_b;
        end
        chk("cl_fault_cycles", fault_cycles, 0);
        chk("cl_laps_a_ge2", int'(laps_a >= 2), 1);
        chk("cl_laps_b_ge2", int'(laps_b >= 2), 1);
        chk("cl_lap_a", lap_a, laps_a * LAPEN);
        chk("cl_lap_b", lap_b, laps_b * LAPEN);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
